// File: rtl/wb_regfile_stage_if.sv
// MEM/WB writeback inputs, ID read ports and debug outputs of the regfile stage.
// Latency: pure wiring, none.
// Backpressure: none; the stage accepts one writeback every cycle.
interface wb_regfile_stage_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
);
  localparam int AW = $clog2(NREGS);

  // MEM/WB pipeline register outputs
  logic [1:0]        wb_ctl_in;      // [1] RegWrite, [0] MemtoReg
  logic [DATA_W-1:0] read_data_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [AW-1:0]     write_reg_in;

  // ID-stage read ports
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Forwarding and debug
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output wb_ctl_in, read_data_in, alu_result_in, write_reg_in, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_en, wb_count
  );

  modport slave (
    input  wb_ctl_in, read_data_in, alu_result_in, write_reg_in, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_en, wb_count
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// MIPS writeback select plus 32x32 register file with write-first read bypass.
// Latency: wb_data/wb_en/reads combinational; array and wb_count update at the clock edge.
// Backpressure: none; one write can commit every cycle, reads never stall.
module wb_regfile_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic clk,
  input  logic reset,
  wb_regfile_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [CNT_W-1:0]  r_wb_count;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_en;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  // Writeback source select and effective enable ($0 writes are dropped here)
  always_comb begin
    w_wb_data = bus.wb_ctl_in[0] ? bus.read_data_in : bus.alu_result_in;
    w_wb_en   = bus.wb_ctl_in[1] && (bus.write_reg_in != '0);
  end

  // Read ports: $0 reads zero, a same-cycle write to the address wins over the array
  always_comb begin
    w_rs_data = r_regs[bus.rs_addr];
    w_rt_data = r_regs[bus.rt_addr];
    if (w_wb_en && (bus.rs_addr == bus.write_reg_in)) begin
      w_rs_data = w_wb_data;
    end
    if (w_wb_en && (bus.rt_addr == bus.write_reg_in)) begin
      w_rt_data = w_wb_data;
    end
    if (bus.rs_addr == '0) begin
      w_rs_data = '0;
    end
    if (bus.rt_addr == '0) begin
      w_rt_data = '0;
    end
  end

  // Array commit: reset clears everything and discards the write on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[bus.write_reg_in] <= w_wb_data;
    end
  end

  // Retired-write counter, wraps naturally at full scale
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_count <= '0;
    end else if (w_wb_en) begin
      r_wb_count <= r_wb_count + CNT_W'(1);
    end
  end

  assign bus.wb_data  = w_wb_data;
  assign bus.wb_en    = w_wb_en;
  assign bus.rs_data  = w_rs_data;
  assign bus.rt_data  = w_rt_data;
  assign bus.wb_count = r_wb_count;

  // AW is only used implicitly through the interface address widths
  logic [AW-1:0] w_unused_aw;
  assign w_unused_aw = '0;
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed table, hand sequences, random vs model.
// Latency: checks combinational outputs before the edge, wb_count after it.
// Backpressure: none exercised; stage never stalls.
module tb_wb_regfile_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  wb_regfile_stage_if #(.DATA_W(32), .NREGS(32), .CNT_W(32)) bus ();

  wb_regfile_stage #(.DATA_W(32), .NREGS(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  ctl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_wb;
    logic        e_en;
    logic [31:0] e_cnt;   // wb_count after the edge
  } vec_t;

  vec_t vecs [12];

  // behavioural reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ctl, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
    bus.wb_ctl_in     = ctl;
    bus.read_data_in  = rd;
    bus.alu_result_in = alu;
    bus.write_reg_in  = wr;
    bus.rs_addr       = rs;
    bus.rt_addr       = rt;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_wb, e_rs, e_rt;
    logic        e_en;
    logic        do_rst;

    vecs[0]  = '{2'b10, 32'h0,        32'hDEADBEEF, 5'd5,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b1, 32'd1};
    vecs[1]  = '{2'b00, 32'h0,        32'h0,        5'd0,  5'd5,  5'd31, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 32'd1};
    vecs[2]  = '{2'b11, 32'h12345678, 32'h0,        5'd31, 5'd0,  5'd31, 32'h0,        32'h12345678, 32'h12345678, 1'b1, 32'd2};
    vecs[3]  = '{2'b00, 32'h0,        32'h0,        5'd0,  5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'h0,        1'b0, 32'd2};
    vecs[4]  = '{2'b10, 32'h0,        32'hA5A5A5A5, 5'd7,  5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 32'd3};
    vecs[5]  = '{2'b00, 32'h0,        32'h0,        5'd0,  5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        1'b0, 32'd3};
    vecs[6]  = '{2'b10, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'd3};
    vecs[7]  = '{2'b00, 32'h0,        32'h0,        5'd0,  5'd0,  5'd7,  32'h0,        32'hA5A5A5A5, 32'h0,        1'b0, 32'd3};
    vecs[8]  = '{2'b01, 32'h1,        32'h0,        5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        32'h1,        1'b0, 32'd3};
    vecs[9]  = '{2'b00, 32'h0,        32'h0,        5'd0,  5'd9,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 32'd3};
    vecs[10] = '{2'b10, 32'h0,        32'hCAFEF00D, 5'd5,  5'd5,  5'd31, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 1'b1, 32'd4};
    vecs[11] = '{2'b00, 32'h0,        32'h0,        5'd0,  5'd5,  5'd5,  32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        1'b0, 32'd4};

    // ---- reset then sweep reads ----
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wb_count", bus.wb_count, 32'h0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    check("rst_wb_en", {31'h0, bus.wb_en}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.rs_addr = a[4:0];
      bus.rt_addr = 5'(31 - a);
      #1;
      check("rst_sweep_rs", bus.rs_data, 32'h0);
      check("rst_sweep_rt", bus.rt_data, 32'h0);
    end

    // ---- directed table ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].ctl, vecs[i].rd, vecs[i].alu, vecs[i].wr, vecs[i].rs, vecs[i].rt);
      #1;
      check($sformatf("vec%0d_rs", i), bus.rs_data, vecs[i].e_rs);
      check($sformatf("vec%0d_rt", i), bus.rt_data, vecs[i].e_rt);
      check($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].e_wb);
      check($sformatf("vec%0d_wb_en", i), {31'h0, bus.wb_en}, {31'h0, vecs[i].e_en});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), bus.wb_count, vecs[i].e_cnt);
    end

    // ---- reset priority mid-stream ----
    @(negedge clk);
    drive(2'b10, 32'h0, 32'h11, 5'd3, 5'd3, 5'd4);
    @(negedge clk);
    drive(2'b10, 32'h0, 32'h22, 5'd4, 5'd3, 5'd4);
    reset = 1'b1;
    #1;
    check("rstpri_r3_before", bus.rs_data, 32'h11);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);
    #1;
    check("rstpri_r3", bus.rs_data, 32'h0);
    check("rstpri_r4", bus.rt_data, 32'h0);
    check("rstpri_count", bus.wb_count, 32'h0);

    // ---- counter wrap ----
    @(negedge clk);
    force dut.r_wb_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wb_count;
    drive(2'b10, 32'h0, 32'h77, 5'd2, 5'd2, 5'd0);
    @(posedge clk);
    #1;
    check("wrap_count", bus.wb_count, 32'h0);
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0);
    #1;
    check("wrap_r2", bus.rs_data, 32'h77);

    // ---- randomized run against reference model ----
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      do_rst = ($urandom_range(0, 39) == 0);
      reset  = do_rst;
      drive(2'($urandom), $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1;
      e_wb = bus.wb_ctl_in[0] ? bus.read_data_in : bus.alu_result_in;
      e_en = bus.wb_ctl_in[1] && (bus.write_reg_in != 5'd0);
      if (bus.rs_addr == 5'd0)                         e_rs = 32'h0;
      else if (e_en && bus.rs_addr == bus.write_reg_in) e_rs = e_wb;
      else                                              e_rs = m_regs[bus.rs_addr];
      if (bus.rt_addr == 5'd0)                         e_rt = 32'h0;
      else if (e_en && bus.rt_addr == bus.write_reg_in) e_rt = e_wb;
      else                                              e_rt = m_regs[bus.rt_addr];
      check("rnd_wb_data", bus.wb_data, e_wb);
      check("rnd_wb_en", {31'h0, bus.wb_en}, {31'h0, e_en});
      check("rnd_rs", bus.rs_data, e_rs);
      check("rnd_rt", bus.rt_data, e_rt);
      @(posedge clk);
      if (do_rst) begin
        model_reset();
      end else if (e_en) begin
        m_regs[bus.write_reg_in] = e_wb;
        m_cnt = m_cnt + 32'd1;
      end
      #1;
      check("rnd_count", bus.wb_count, m_cnt);
    end
    reset = 1'b0;

    // final full-array comparison against the model
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      bus.rs_addr = a[4:0];
      bus.rt_addr = a[4:0];
      #1;
      check("final_rs", bus.rs_data, m_regs[a]);
      check("final_rt", bus.rt_data, m_regs[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
